// File: rtl/io_timer_responder_pkg.sv
// Shared definitions for the I/O timer responder: register offsets, control/status
// bit positions and the bus handshake state encoding.
package io_timer_responder_pkg;

    localparam logic [2:0] RegCtrl     = 3'd0;
    localparam logic [2:0] RegStatus   = 3'd1;
    localparam logic [2:0] RegReloadL  = 3'd2;
    localparam logic [2:0] RegReloadH  = 3'd3;
    localparam logic [2:0] RegCountL   = 3'd4;
    localparam logic [2:0] RegCountH   = 3'd5;
    localparam logic [2:0] RegPrescale = 3'd6;
    localparam logic [2:0] RegRsvd     = 3'd7;

    localparam int unsigned CtrlEnBit        = 0;
    localparam int unsigned CtrlAutoBit      = 1;
    localparam int unsigned CtrlIrqEnBit     = 2;
    localparam int unsigned StatusExpiredBit = 0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck,
        StHold
    } bus_state_e;

endpackage

// File: rtl/io_bus_wait_fsm.sv
// Bus handshake for the timer window: inserts wait states, produces the single-cycle
// commit strobes and requires both strobes to be released before accepting a new access.
module io_bus_wait_fsm
    import io_timer_responder_pkg::*;
#(
    parameter int unsigned WaitCycles = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic sel_i,
    input  logic rd_n_i,
    input  logic wr_n_i,
    output logic pin_wait_o,
    output logic data_oe_o,
    output logic wr_commit_o,
    output logic rd_commit_o
);

    localparam logic [3:0] WaitLoad = 4'(WaitCycles);

    bus_state_e state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       is_rd_q, is_rd_d;
    logic       armed_q, armed_d;
    logic       released;

    assign released = rd_n_i & wr_n_i;

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            is_rd_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            is_rd_q    <= is_rd_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        is_rd_d     = is_rd_q;
        // armed only after both strobes have been seen high since the last access/reset
        armed_d     = armed_q | released;
        pin_wait_o  = 1'b0;
        wr_commit_o = 1'b0;
        rd_commit_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sel_i && armed_q) begin
                    state_d    = StWait;
                    wait_cnt_d = WaitLoad;
                    is_rd_d    = ~rd_n_i;
                    armed_d    = 1'b0;
                end
            end
            StWait: begin
                pin_wait_o = 1'b1;
                if (!sel_i) begin
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                wr_commit_o = ~is_rd_q;
                rd_commit_o = is_rd_q;
                state_d     = StHold;
            end
            StHold: begin
                if (released) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_oe_o = is_rd_q && (state_q != StIdle);

endmodule

// File: rtl/io_timer_responder.sv
// I/O-mapped 16-bit down-counting timer with prescaler, auto-reload and level interrupt,
// behind an 8-register window with wait-state bus handshake.
module io_timer_responder
    import io_timer_responder_pkg::*;
#(
    parameter logic [21:0] BASE_ADDR   = 22'h000040,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [21:0] address_bus,
    input  logic [7:0]  data_in,
    input  logic        rd,
    input  logic        wr,
    input  logic        mem_io,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        pin_wait,
    output logic        irq
);

    logic       sel;
    logic [2:0] reg_addr;
    logic       wr_commit, rd_commit;

    assign sel      = !mem_io && (address_bus[21:3] == BASE_ADDR[21:3]) && ((!rd) ^ (!wr));
    assign reg_addr = address_bus[2:0];

    io_bus_wait_fsm #(
        .WaitCycles (WAIT_CYCLES)
    ) u_bus_fsm (
        .clk_i       (clk),
        .arst_i      (arst),
        .sel_i       (sel),
        .rd_n_i      (rd),
        .wr_n_i      (wr),
        .pin_wait_o  (pin_wait),
        .data_oe_o   (data_oe),
        .wr_commit_o (wr_commit),
        .rd_commit_o (rd_commit)
    );

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        irq_en_q, irq_en_d;
    logic        expired_q, expired_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        irq_q, irq_d;

    logic wr_ctrl, wr_status, wr_reload_l, wr_reload_h, wr_presc;
    logic tick, expire;

    assign wr_ctrl     = wr_commit && (reg_addr == RegCtrl);
    assign wr_status   = wr_commit && (reg_addr == RegStatus);
    assign wr_reload_l = wr_commit && (reg_addr == RegReloadL);
    assign wr_reload_h = wr_commit && (reg_addr == RegReloadH);
    assign wr_presc    = wr_commit && (reg_addr == RegPrescale);

    always_ff @(posedge clk) begin
        if (arst) begin
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            expired_q <= 1'b0;
            reload_q  <= '0;
            count_q   <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            shadow_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            auto_q    <= auto_d;
            irq_en_q  <= irq_en_d;
            expired_q <= expired_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            shadow_q  <= shadow_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        en_d      = en_q;
        auto_d    = auto_q;
        irq_en_d  = irq_en_q;
        expired_d = expired_q;
        reload_d  = reload_q;
        count_d   = count_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        shadow_d  = shadow_q;

        // a CTRL write clearing en in this cycle swallows the tick
        tick   = en_q && (pcnt_q == 8'd0) && !(wr_ctrl && !data_in[CtrlEnBit]);
        expire = tick && (count_q == 16'd0);

        if (en_q) begin
            pcnt_d = (pcnt_q == 8'd0) ? presc_q : pcnt_q - 8'd1;
        end

        if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (auto_q) begin
                count_d = reload_q;
            end else begin
                en_d = 1'b0;
            end
        end

        // expiry takes priority over a simultaneous write-1-clear
        if (wr_status && data_in[StatusExpiredBit]) begin
            expired_d = 1'b0;
        end
        if (expire) begin
            expired_d = 1'b1;
        end

        if (wr_ctrl) begin
            en_d     = data_in[CtrlEnBit];
            auto_d   = data_in[CtrlAutoBit];
            irq_en_d = data_in[CtrlIrqEnBit];
            if (!en_q && data_in[CtrlEnBit]) begin
                count_d = reload_q;
                pcnt_d  = presc_q;
            end
        end

        if (wr_reload_l) begin
            reload_d[7:0] = data_in;
            if (!en_q) begin
                count_d = {reload_q[15:8], data_in};
            end
        end
        if (wr_reload_h) begin
            reload_d[15:8] = data_in;
            if (!en_q) begin
                count_d = {data_in, reload_q[7:0]};
            end
        end

        if (wr_presc) begin
            presc_d = data_in;
        end

        if (rd_commit && (reg_addr == RegCountL)) begin
            shadow_d = count_q[15:8];
        end

        irq_d = expired_q && irq_en_q;
    end

    logic [7:0] rd_data;

    always_comb begin
        rd_data = 8'h00;
        unique case (reg_addr)
            RegCtrl:     rd_data = {5'b0, irq_en_q, auto_q, en_q};
            RegStatus:   rd_data = {7'b0, expired_q};
            RegReloadL:  rd_data = reload_q[7:0];
            RegReloadH:  rd_data = reload_q[15:8];
            RegCountL:   rd_data = count_q[7:0];
            RegCountH:   rd_data = shadow_q;
            RegPrescale: rd_data = presc_q;
            RegRsvd:     rd_data = 8'h00;
            default:     rd_data = 8'h00;
        endcase
    end

    assign data_out = data_oe ? rd_data : 8'h00;
    assign irq      = irq_q;

endmodule

// File: tb/tb_io_timer_responder.sv
// Directed bench for io_timer_responder: stimulus queues expected wait widths and read
// data; a negedge monitor pops and compares them when the DUT ends each wait period.
module tb_io_timer_responder;

    localparam logic [21:0] Base  = 22'h000040;
    localparam int          WaitN = 2;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [21:0] address_bus = '0;
    logic [7:0]  data_in = '0;
    logic        rd = 1'b1;
    logic        wr = 1'b1;
    logic        mem_io = 1'b0;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        pin_wait;
    logic        irq;

    io_timer_responder #(
        .BASE_ADDR   (Base),
        .WAIT_CYCLES (WaitN)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .address_bus (address_bus),
        .data_in     (data_in),
        .rd          (rd),
        .wr          (wr),
        .mem_io      (mem_io),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .pin_wait    (pin_wait),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    string      w_nm[$];
    int         w_val[$];
    string      r_nm[$];
    logic [7:0] r_val[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on each pin_wait fall, compare wait width and (for reads) the ACK-cycle data.
    initial begin
        int   wcnt;
        logic prev_pw;
        wcnt    = 0;
        prev_pw = 1'b0;
        forever begin
            @(negedge clk);
            if (pin_wait === 1'b1) begin
                wcnt++;
            end else if (prev_pw === 1'b1) begin
                if (w_nm.size() == 0) begin
                    check("unexpected_wait", 32'(wcnt), 32'd0);
                end else begin
                    check(w_nm.pop_front(), 32'(wcnt), 32'(w_val.pop_front()));
                end
                if (data_oe === 1'b1) begin
                    if (r_nm.size() == 0) begin
                        check("unexpected_read", 32'(data_out), 32'hFFFF);
                    end else begin
                        check(r_nm.pop_front(), 32'(data_out), 32'(r_val.pop_front()));
                    end
                end
                wcnt = 0;
            end
            prev_pw = pin_wait;
        end
    end

    // One release cycle, then strobe low; commit lands on the 4th edge; strobe released after it.
    task automatic bus(input bit is_wr, input logic [2:0] r, input logic [7:0] d, input bit mio,
                       input string nm);
        bit act;
        act = 1'b0;
        @(posedge clk); #1;
        address_bus = Base + 22'(r);
        mem_io      = mio;
        data_in     = d;
        if (is_wr) wr = 1'b0;
        else rd = 1'b0;
        if (!mio) begin
            w_nm.push_back({nm, "_wait"});
            w_val.push_back(WaitN);
        end
        repeat (4) begin
            @(posedge clk); #1;
            act |= pin_wait | data_oe;
        end
        rd     = 1'b1;
        wr     = 1'b1;
        mem_io = 1'b0;
        if (mio) check({nm, "_no_response"}, 32'(act), 32'd0);
    endtask

    task automatic wr_reg(input logic [2:0] r, input logic [7:0] d, input string nm);
        bus(1'b1, r, d, 1'b0, nm);
    endtask

    task automatic rd_reg(input logic [2:0] r, input logic [7:0] exp, input string nm);
        r_nm.push_back(nm);
        r_val.push_back(exp);
        bus(1'b0, r, 8'h00, 1'b0, nm);
    endtask

    initial begin
        bit pw_seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pin_wait", 32'(pin_wait), 32'd0);
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        arst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_reg(3'(i), 8'h00, $sformatf("rst_reg%0d", i));
        end

        // RELOAD write/readback; count follows reload while disabled; shadow latch
        wr_reg(3'd2, 8'h34, "wr_reload_l");
        wr_reg(3'd3, 8'h12, "wr_reload_h");
        rd_reg(3'd2, 8'h34, "rd_reload_l");
        rd_reg(3'd3, 8'h12, "rd_reload_h");
        rd_reg(3'd4, 8'h34, "rd_count_l");
        rd_reg(3'd5, 8'h12, "rd_count_h_shadow");
        rd_reg(3'd7, 8'h00, "rd_reserved");

        // Memory cycle to the same address is ignored
        bus(1'b1, 3'd2, 8'hAA, 1'b1, "mem_cycle");
        rd_reg(3'd2, 8'h34, "rd_reload_l_after_mem");

        // PRESCALE=0, RELOAD=3, CTRL=111: expiry on 4th tick, irq one cycle later
        wr_reg(3'd6, 8'h00, "wr_presc0");
        wr_reg(3'd2, 8'h03, "wr_reload3_l");
        wr_reg(3'd3, 8'h00, "wr_reload3_h");
        wr_reg(3'd0, 8'h07, "wr_ctrl7");
        repeat (4) @(posedge clk);
        #1;
        check("irq_before_latency", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_after_expiry", 32'(irq), 32'd1);
        // Stop during ACK: count 3,2,1,0,3,2,1,0,3,2 then suppressed tick keeps 2
        wr_reg(3'd0, 8'h04, "wr_ctrl_stop");
        rd_reg(3'd4, 8'h02, "rd_count_reloaded");
        rd_reg(3'd1, 8'h01, "rd_status_expired");
        wr_reg(3'd1, 8'h01, "wr_status_clear");
        check("irq_still_high", 32'(irq), 32'd1);
        @(posedge clk); #1;
        check("irq_cleared", 32'(irq), 32'd0);
        rd_reg(3'd1, 8'h00, "rd_status_cleared");

        // One-shot: PRESCALE=4, RELOAD=0 -> expiry 5 cycles after enable, en drops
        wr_reg(3'd6, 8'h04, "wr_presc4");
        wr_reg(3'd2, 8'h00, "wr_reload0_l");
        wr_reg(3'd3, 8'h00, "wr_reload0_h");
        wr_reg(3'd0, 8'h05, "wr_ctrl_oneshot");
        repeat (5) @(posedge clk);
        #1;
        check("oneshot_irq_early", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("oneshot_irq", 32'(irq), 32'd1);
        rd_reg(3'd0, 8'h04, "rd_ctrl_en_cleared");
        rd_reg(3'd4, 8'h00, "rd_count_held0");
        rd_reg(3'd1, 8'h01, "rd_status_oneshot");

        // STATUS clear in the same cycle as expiry: expiry wins
        wr_reg(3'd1, 8'h01, "wr_status_preclear");
        wr_reg(3'd2, 8'h04, "wr_reload4_l");
        wr_reg(3'd3, 8'h00, "wr_reload4_h");
        wr_reg(3'd6, 8'h00, "wr_presc0b");
        rd_reg(3'd1, 8'h00, "rd_status_pre");
        wr_reg(3'd0, 8'h01, "wr_ctrl_en_only");
        wr_reg(3'd1, 8'h01, "wr_status_collide");
        rd_reg(3'd1, 8'h01, "rd_status_expiry_wins");
        rd_reg(3'd0, 8'h00, "rd_ctrl_after_collide");

        // Reset in the 2nd WAIT cycle of a RELOAD_L write
        @(posedge clk); #1;
        address_bus = Base + 22'd2;
        data_in     = 8'h5A;
        wr          = 1'b0;
        w_nm.push_back("rst_abort_wait");
        w_val.push_back(WaitN);
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
        check("rst_abort_pin_wait", 32'(pin_wait), 32'd0);
        pw_seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            pw_seen |= pin_wait | data_oe;
        end
        check("rst_abort_no_restart", 32'(pw_seen), 32'd0);
        wr = 1'b1;
        rd_reg(3'd2, 8'h00, "rd_reload_l_after_abort");
        wr_reg(3'd2, 8'h5A, "wr_after_abort");
        rd_reg(3'd2, 8'h5A, "rd_after_abort");

        repeat (3) @(posedge clk);
        check("wait_queue_drained", 32'(w_nm.size()), 32'd0);
        check("read_queue_drained", 32'(r_nm.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/io_timer_responder.md
IO_TIMER_RESPONDER -- requirements
Module: io_timer_responder

Interface
REQ-001 Parameter BASE_ADDR, default 22'h000040: I/O base address of the 8-register window; bits [2:0] are ignored.
REQ-002 Parameter WAIT_CYCLES, default 2: number of wait-state cycles inserted per access, legal range 1..15.
REQ-003 clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 arst  input  1  reset; synchronous and active-high.
REQ-005 address_bus  input  22  address driven by the CPU.
REQ-006 data_in  input  8  write data from the CPU data_bus_out.
REQ-007 rd  input  1  read strobe, active low.
REQ-008 wr  input  1  write strobe, active low.
REQ-009 mem_io  input  1  1 = memory cycle, 0 = I/O cycle.
REQ-010 data_out  output  8  read data to the CPU data_bus_in.
REQ-011 data_oe  output  1  high while the block drives data_out.
REQ-012 pin_wait  output  1  active-high wait request to the CPU.
REQ-013 irq  output  1  level interrupt request to one pins_irq_req line.

Function
REQ-014 Select: sel = (mem_io==0) and (address_bus[21:3]==BASE_ADDR[21:3]) and (rd==0 xor wr==0).
- Both strobes low at once is ignored.
- reg = address_bus[2:0].
REQ-015 Register map:
- 0 CTRL: bit0 en, bit1 auto_reload, bit2 irq_en.
- 1 STATUS: bit0 expired; writing 1 clears it.
- 2 RELOAD_L.
- 3 RELOAD_H.
- 4 COUNT_L: a read returns count[7:0] and latches count[15:8] into the shadow register.
- 5 COUNT_H_SHADOW: read-only.
- 6 PRESCALE.
- 7: reads 0, writes ignored.
REQ-016 Bus FSM states: IDLE, WAIT, ACK, HOLD.
REQ-017 IDLE -> WAIT on the first cycle sel is true. Load the wait counter with WAIT_CYCLES and assert pin_wait.
REQ-018 WAIT: decrement the counter each cycle. When it reaches 0, go to ACK and deassert pin_wait.
- pin_wait is high for exactly WAIT_CYCLES cycles.
REQ-019 ACK: a write commits data_in to the register on this single cycle. Then go to HOLD.
REQ-020 HOLD: stay until both strobes are high, then go to IDLE.
- A second access requires strobe release first.
REQ-021 If sel drops during WAIT (aborted cycle), go to IDLE, deassert pin_wait, and commit nothing.
REQ-022 data_oe = 1 in WAIT, ACK and HOLD of a read cycle; 0 otherwise.
- data_out is valid from the first WAIT cycle onward.
- data_out = 8'h00 when data_oe = 0.
REQ-023 Prescaler: an 8-bit down-counter.
- While en = 1: when it equals 0, emit a tick and reload it with PRESCALE; otherwise decrement it.
- A tick therefore occurs every PRESCALE+1 cycles.
REQ-024 On tick with count != 0: count decrements by 1, modulo 16 bits.
REQ-025 On tick with count == 0: set expired = 1, then:
- if auto_reload = 1, count <= {RELOAD_H, RELOAD_L};
- if auto_reload = 0, en <= 0 and count stays 0.
REQ-026 Writing CTRL.en from 0 to 1 loads count from RELOAD and the prescaler from PRESCALE in the same cycle.
REQ-027 A write to RELOAD_L/H while en = 0 also copies the reload value into count.
REQ-028 Simultaneous expiry and STATUS write-1-clear in the same cycle: expired ends at 1 (expiry wins).
REQ-029 irq = expired AND irq_en, registered, with 1-cycle latency after expired sets.
REQ-030 A CTRL write that clears en during the ACK cycle suppresses a tick in that same cycle.

Reset
REQ-031 While arst = 1 at a clk edge, the block SHALL go to this state:
- FSM = IDLE; wait counter = 0.
- All registers, count, prescaler and shadow = 0.
- Outputs: pin_wait = 0, data_oe = 0, data_out = 0, irq = 0.
REQ-032 Reset during an active access SHALL abandon it without committing the write.
- pin_wait drops on the next edge.
- After reset the FSM returns to IDLE and accepts a new access only once both strobes have been seen high.

Structure
REQ-033 A shared package SHALL hold:
- the register-offset localparams;
- CTRL/STATUS bit positions;
- the FSM state enum.
REQ-034 The block SHALL contain exactly one sub-module, io_bus_wait_fsm: decode handshake, wait counter and strobe tracking.
- The timer/register logic stays in the parent.

Verification
REQ-035 I/O write 8'h34 to base+2 and 8'h12 to base+3 with WAIT_CYCLES=2 -> pin_wait high exactly 2 cycles each; readback of RELOAD = 16'h1234.
REQ-036 Same address with mem_io=1 -> no pin_wait, data_oe stays 0, no register change.
REQ-037 PRESCALE=0, RELOAD=3, CTRL=3'b111 -> expired after 4 ticks; irq high 1 cycle later; count reloads to 3; STATUS write 1 -> irq low.
REQ-038 auto_reload=0, RELOAD=0, PRESCALE=4 -> expiry 5 cycles after enable; en reads back 0; count holds 0.
REQ-039 STATUS write-1-clear lands in the ACK cycle coinciding with expiry -> expired remains 1.
REQ-040 Assert arst in the 2nd WAIT cycle of a write to RELOAD_L -> register unchanged, pin_wait low on the next edge, FSM idle until strobes release.
